// File: rtl/cordic_prerotate.sv
// ============================================================================
// Module      : cordic_prerotate
// Description : CORDIC input stage: pi pre-rotation fold into the convergence
//               range, behind a valid/ready skid buffer. Optional saturation
//               event counter enabled by defining CORDIC_PREROT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_prerotate #(
  parameter int FUNC_WIDTH    = 1,
  parameter int DATA_OP_WIDTH = 18,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [FUNC_WIDTH-1:0]           i_func,
  input  logic signed [DATA_OP_WIDTH-1:0] i_x,
  input  logic signed [DATA_OP_WIDTH-1:0] i_y,
  input  logic signed [DATA_OP_WIDTH-1:0] i_z,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [FUNC_WIDTH-1:0]           o_func,
  output logic signed [DATA_OP_WIDTH-1:0] o_x,
  output logic signed [DATA_OP_WIDTH-1:0] o_y,
  output logic signed [DATA_OP_WIDTH-1:0] o_z,
  output logic                            o_fold,
  output logic [CNT_WIDTH-1:0]            o_sat_cnt
);

  localparam int W  = DATA_OP_WIDTH;
  localparam int PW = FUNC_WIDTH + 3 * W + 1;

  localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    return (v == c_MIN) ? c_MAX : -v;
  endfunction

  logic          w_fold;
  logic [W-1:0]  w_x_n;
  logic [W-1:0]  w_y_n;
  logic [W-1:0]  w_z_n;
  logic [PW-1:0] w_in;
  logic          w_accept;
  logic          w_load_out;
  logic          w_load_skid;
  logic          w_skid_to_out;
  logic [1:0]    w_state_nxt;
  logic [1:0]    r_state;
  logic          r_ready;
  logic [PW-1:0] r_out;
  logic [PW-1:0] r_skid;

  // Rotation folds when the top two angle bits differ (|z| >= pi/2); vectoring folds on negative x.
  assign w_fold = (i_func == '0) ? (i_z[W-1] ^ i_z[W-2]) : i_x[W-1];
  assign w_x_n  = w_fold ? sat_neg(i_x) : i_x;
  assign w_y_n  = w_fold ? sat_neg(i_y) : i_y;
  assign w_z_n  = w_fold ? {~i_z[W-1], i_z[W-2:0]} : i_z;
  assign w_in   = {i_func, w_x_n, w_y_n, w_z_n, w_fold};

  assign w_accept = i_valid & r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != c_FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: if (w_accept) w_state_nxt = c_ONE;
      c_ONE: begin
        if (w_accept && !i_ready)      w_state_nxt = c_FULL;
        else if (!w_accept && i_ready) w_state_nxt = c_EMPTY;
      end
      c_FULL:  if (i_ready) w_state_nxt = c_ONE;
      default: w_state_nxt = c_EMPTY;
    endcase
  end

  always_comb begin
    o_valid       = (r_state != c_EMPTY);
    o_ready       = r_ready;
    w_load_out    = w_accept & ((r_state == c_EMPTY) | ((r_state == c_ONE) & i_ready));
    w_load_skid   = w_accept & (r_state == c_ONE) & ~i_ready;
    w_skid_to_out = (r_state == c_FULL) & i_ready;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_skid_to_out)   r_out <= r_skid;
      else if (w_load_out) r_out <= w_in;
      if (w_load_skid)     r_skid <= w_in;
    end
  end

  assign {o_func, o_x, o_y, o_z, o_fold} = r_out;

`ifdef CORDIC_PREROT_CNT_EN
  logic                 w_sat;
  logic [CNT_WIDTH-1:0] r_sat_cnt;

  // One event per operand, even if both lanes saturate.
  assign w_sat = w_fold & ((i_x == c_MIN) | (i_y == c_MIN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sat_cnt <= '0;
    end else if (w_accept && w_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_sat_cnt = r_sat_cnt;
`else
  assign o_sat_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cordic_prerotate.sv
// ============================================================================
// Module      : tb_cordic_prerotate
// Description : Self-checking bench for cordic_prerotate (queue-based model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_prerotate;

  localparam int W    = 18;
  localparam int FW   = 1;
  localparam int CW   = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int QPI  = 1 << (W - 2);

  logic                clk = 1'b0;
  logic                rst;
  logic                i_valid;
  logic                o_ready;
  logic [FW-1:0]       i_func;
  logic signed [W-1:0] i_x, i_y, i_z;
  logic                o_valid;
  logic                i_ready;
  logic [FW-1:0]       o_func;
  logic signed [W-1:0] o_x, o_y, o_z;
  logic                o_fold;
  logic [CW-1:0]       o_sat_cnt;

  cordic_prerotate #(.FUNC_WIDTH(FW), .DATA_OP_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_func(i_func), .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .o_valid(o_valid), .i_ready(i_ready), .o_func(o_func),
    .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_fold(o_fold), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f; int x; int y; int z; int fold; int sat;
  } op_t;

  op_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  out_cnt = 0;
  int  acc_cnt = 0;
  int  mcnt = 0;
  bit  last_acc = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Fold expressed arithmetically: |z| >= pi/2, z -> z + pi wrapped into [-pi, pi).
  function automatic op_t model(input int f, input int x, input int y, input int z);
    op_t r;
    r.f = f; r.x = x; r.y = y; r.z = z; r.sat = 0;
    r.fold = (f == 0) ? int'(z >= QPI || z < -QPI) : int'(x < 0);
    if (r.fold != 0) begin
      r.x = -x;
      r.y = -y;
      if (r.x > MAXV) begin r.x = MAXV; r.sat = 1; end
      if (r.y > MAXV) begin r.y = MAXV; r.sat = 1; end
      r.z = z + (MAXV + 1);
      if (r.z > MAXV) r.z = r.z - 2 * (MAXV + 1);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    op_t e;
    if (rst) begin
      q.delete();
      mcnt = 0;
      last_acc = 1'b0;
      chk("rst_valid", longint'(o_valid), 0);
      chk("rst_ready", longint'(o_ready), 1);
    end else begin
      chk("valid_vs_model", longint'(o_valid), longint'(q.size() > 0));
      chk("ready_vs_model", longint'(o_ready), longint'(q.size() < 2));
      chk("sat_cnt", longint'(o_sat_cnt), mcnt);
      if (o_valid && q.size() > 0) begin
        e = q[0];
        chk("out_func", longint'(o_func), e.f);
        chk("out_x", longint'($signed(o_x)), e.x);
        chk("out_y", longint'($signed(o_y)), e.y);
        chk("out_z", longint'($signed(o_z)), e.z);
        chk("out_fold", longint'(o_fold), e.fold);
        if (i_ready) begin
          void'(q.pop_front());
          out_cnt++;
        end
      end
      last_acc = i_valid && o_ready;
      if (last_acc) begin
        e = model(int'(i_func), int'($signed(i_x)), int'($signed(i_y)), int'($signed(i_z)));
        q.push_back(e);
        acc_cnt++;
`ifdef CORDIC_PREROT_CNT_EN
        if (e.sat != 0 && mcnt < (1 << CW) - 1) mcnt++;
`endif
      end
    end
  end

  task automatic drive(input bit v, input int f, input int x, input int y, input int z, input bit rdy);
    @(posedge clk);
    #1;
    i_valid = v;
    i_func  = f[FW-1:0];
    i_x     = x[W-1:0];
    i_y     = y[W-1:0];
    i_z     = z[W-1:0];
    i_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  function automatic int rnd_op();
    int v;
    if ($urandom_range(0, 7) == 0) return -(MAXV + 1);
    v = int'($urandom_range(0, 2 * MAXV + 1));
    if (v > MAXV) v = v - 2 * (MAXV + 1);
    return v;
  endfunction

  initial begin
    int k, c, nfull, base;
    rst = 1'b1;
    i_valid = 1'b0; i_func = '0; i_x = '0; i_y = '0; i_z = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_valid", longint'(o_valid), 0);
    chk("reset_o_ready", longint'(o_ready), 1);
    chk("reset_o_x", longint'($signed(o_x)), 0);
    chk("reset_o_fold", longint'(o_fold), 0);
    chk("reset_sat_cnt", longint'(o_sat_cnt), 0);
    rst = 1'b0;

    drive(1'b1, 0, 1000, 0, 98304, 1'b1); idle(1);
    chk("t1_x", longint'($signed(o_x)), -1000);
    chk("t1_y", longint'($signed(o_y)), 0);
    chk("t1_z", longint'($signed(o_z)), -32768);
    chk("t1_fold", longint'(o_fold), 1);

    drive(1'b1, 1, -500, 300, 0, 1'b1); idle(1);
    chk("t2_x", longint'($signed(o_x)), 500);
    chk("t2_y", longint'($signed(o_y)), -300);
    chk("t2_z", longint'($signed(o_z)), -131072);
    chk("t2_fold", longint'(o_fold), 1);
    drive(1'b1, 1, 500, 300, 0, 1'b1); idle(1);
    chk("t2b_x", longint'($signed(o_x)), 500);
    chk("t2b_z", longint'($signed(o_z)), 0);
    chk("t2b_fold", longint'(o_fold), 0);

    drive(1'b1, 0, -131072, 5, 65536, 1'b1); idle(1);
    chk("t3_x", longint'($signed(o_x)), 131071);
    chk("t3_y", longint'($signed(o_y)), -5);
    chk("t3_z", longint'($signed(o_z)), -65536);
`ifdef CORDIC_PREROT_CNT_EN
    chk("t3_cnt", longint'(o_sat_cnt), 1);
`else
    chk("t3_cnt", longint'(o_sat_cnt), 0);
`endif

    drive(1'b1, 0, 7, 7, 65536, 1'b1); idle(1);
    chk("b_pos_halfpi_z", longint'($signed(o_z)), -65536);
    chk("b_pos_halfpi_fold", longint'(o_fold), 1);
    drive(1'b1, 0, 7, 7, -65536, 1'b1); idle(1);
    chk("b_neg_halfpi_z", longint'($signed(o_z)), -65536);
    chk("b_neg_halfpi_fold", longint'(o_fold), 0);
    drive(1'b1, 1, 0, 9, 0, 1'b1); idle(1);
    chk("b_vec_x0_fold", longint'(o_fold), 0);
    chk("b_vec_x0_y", longint'($signed(o_y)), 9);
    idle(2);

    // Stream 1..8, downstream stalls three cycles mid-stream.
    base = out_cnt; k = 1; c = 0; nfull = 0;
    while (k <= 8 && c < 60) begin
      @(posedge clk);
      if (last_acc) k++;
      #1;
      i_valid = (k <= 8);
      i_func  = '0;
      i_x = k[W-1:0]; i_y = k[W-1:0]; i_z = '0;
      i_ready = !(c >= 3 && c < 6);
      if (!o_ready) nfull++;
      c++;
    end
    idle(5);
    chk("t4_all_accepted", k, 9);
    chk("t4_outputs", out_cnt - base, 8);
    chk("t4_ready_dropped", longint'(nfull > 0), 1);

    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), rnd_op(), rnd_op(), rnd_op(),
            $urandom_range(0, 3) != 0);
    idle(5);
    chk("t5_drained", q.size(), 0);
    base = acc_cnt;
    for (int i = 0; i < 20; i++) drive(1'b1, 0, i, -i, i, 1'b1);
    idle(5);
    chk("t5_throughput", acc_cnt - base, 20);

    drive(1'b1, 0, 11, 12, 13, 1'b0);
    drive(1'b1, 0, 21, 22, 23, 1'b0);
    @(posedge clk); #1;
    chk("t6_full_ready", longint'(o_ready), 0);
    chk("t6_full_valid", longint'(o_valid), 1);
    #2;
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("t6_async_valid", longint'(o_valid), 0);
    chk("t6_async_ready", longint'(o_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    base = out_cnt;
    drive(1'b1, 0, 77, -3, 100, 1'b1); idle(1);
    chk("t6_first_valid", longint'(o_valid), 1);
    chk("t6_first_x", longint'($signed(o_x)), 77);
    chk("t6_first_y", longint'($signed(o_y)), -3);
    chk("t6_first_z", longint'($signed(o_z)), 100);
    chk("t6_first_fold", longint'(o_fold), 0);
    idle(5);
    chk("t6_only_output", out_cnt - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
